// File: rtl/quadrilatero_dispatcher.sv
// quadrilatero_dispatcher
// Issue stage of the matrix coprocessor. Holds one decoded matrix instruction,
// checks it against a per-register scoreboard (write-pending bit plus an
// outstanding-reader counter) for RAW/WAW/WAR hazards and issues it to the
// systolic array (0), LSU (1) or RF (2) over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   instr_*                       decoder-side instruction handshake and fields
//   issue_valid_o / issue_ready_i one-hot issue handshake towards the units
//   issue_*_o                     held instruction fields
//   rd_done_* / wr_done_*         per-port read / write completion releases
//   wbusy_o                       scoreboard write-pending bits
//   idle_o                        nothing held and scoreboard empty
//   err_o                         sticky protocol error
module quadrilatero_dispatcher #(
    parameter int N_REGS      = 8,
    parameter int N_FU        = 3,
    parameter int ID_WIDTH    = 4,
    parameter int READ_PORTS  = 4,
    parameter int WRITE_PORTS = 3,
    parameter int RCNT_W      = 2,
    localparam int RW         = $clog2(N_REGS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    input  logic [1:0]                  instr_fu_i,
    input  logic [3*RW-1:0]             instr_rs_i,
    input  logic [2:0]                  instr_rs_valid_i,
    input  logic [RW-1:0]               instr_rd_i,
    input  logic                        instr_rd_valid_i,
    input  logic [ID_WIDTH-1:0]         instr_id_i,
    output logic [N_FU-1:0]             issue_valid_o,
    input  logic [N_FU-1:0]             issue_ready_i,
    output logic [3*RW-1:0]             issue_rs_o,
    output logic [2:0]                  issue_rs_valid_o,
    output logic [RW-1:0]               issue_rd_o,
    output logic                        issue_rd_valid_o,
    output logic [ID_WIDTH-1:0]         issue_id_o,
    input  logic [READ_PORTS-1:0]       rd_done_valid_i,
    input  logic [READ_PORTS*RW-1:0]    rd_done_reg_i,
    input  logic [WRITE_PORTS-1:0]      wr_done_valid_i,
    input  logic [WRITE_PORTS*RW-1:0]   wr_done_reg_i,
    output logic [N_REGS-1:0]           wbusy_o,
    output logic                        idle_o,
    output logic                        err_o
);

    // Sum width wide enough for counter + three commit increments + three requests.
    localparam int SW      = RCNT_W + 2;
    localparam int CNT_MAX = (1 << RCNT_W) - 1;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t                         r_state;
    logic                           r_issue;
    logic [1:0]                     r_fu;
    logic [3*RW-1:0]                r_rs;
    logic [2:0]                     r_rs_valid;
    logic [RW-1:0]                  r_rd;
    logic                           r_rd_valid;
    logic [ID_WIDTH-1:0]            r_id;
    logic [N_REGS-1:0]              r_wbusy;
    logic [N_REGS-1:0][RCNT_W-1:0]  r_rcnt;
    logic                           r_err;

    logic                           w_fire;
    logic                           w_accept;
    logic                           w_fu_ok;
    logic                           w_hazard;
    logic                           w_err_sb;
    logic [N_FU-1:0]                w_issue_vec;
    logic [3*RW-1:0]                w_c_rs;
    logic [2:0]                     w_c_rs_valid;
    logic [RW-1:0]                  w_c_rd;
    logic                           w_c_rd_valid;
    logic [N_REGS-1:0][1:0]         w_inc;
    logic [N_REGS-1:0]              w_set;
    logic [N_REGS-1:0]              w_wbusy_nxt;
    logic [N_REGS-1:0][RCNT_W-1:0]  w_rcnt_nxt;

    always_comb begin
        w_issue_vec = '0;
        if (r_issue) w_issue_vec[r_fu] = 1'b1;
    end

    assign w_fire        = |(w_issue_vec & issue_ready_i);
    assign instr_ready_o = (r_state == S_IDLE) || w_fire;
    assign w_accept      = instr_valid_i && instr_ready_o;
    assign w_fu_ok       = int'(instr_fu_i) < N_FU;

    // The instruction to check: the incoming one when capturing, else the held one.
    assign w_c_rs       = w_accept ? instr_rs_i       : r_rs;
    assign w_c_rs_valid = w_accept ? instr_rs_valid_i : r_rs_valid;
    assign w_c_rd       = w_accept ? instr_rd_i       : r_rd;
    assign w_c_rd_valid = w_accept ? instr_rd_valid_i : r_rd_valid;

    // Scoreboard updates committed by the instruction firing this cycle.
    always_comb begin
        for (int r = 0; r < N_REGS; r++) begin
            w_inc[r] = 2'd0;
            w_set[r] = w_fire && r_rd_valid && (r_rd == RW'(r));
            for (int s = 0; s < 3; s++) begin
                if (w_fire && r_rs_valid[s] && (r_rs[s*RW +: RW] == RW'(r)))
                    w_inc[r] = w_inc[r] + 2'd1;
            end
        end
    end

    // Hazard check sees registered state plus this cycle's fire commit, so a
    // back-to-back dependent instruction is caught; releases are not bypassed.
    always_comb begin
        logic [SW-1:0] need;
        logic [SW-1:0] fw_cnt;
        logic          fw_wb;
        w_hazard = 1'b0;
        for (int r = 0; r < N_REGS; r++) begin
            need   = '0;
            fw_cnt = SW'(r_rcnt[r]) + SW'(w_inc[r]);
            fw_wb  = r_wbusy[r] || w_set[r];
            for (int s = 0; s < 3; s++) begin
                if (w_c_rs_valid[s] && (w_c_rs[s*RW +: RW] == RW'(r)))
                    need = need + SW'(1);
            end
            if ((need != '0) && fw_wb) w_hazard = 1'b1;
            if ((need != '0) && ((fw_cnt + need) > SW'(CNT_MAX))) w_hazard = 1'b1;
            if (w_c_rd_valid && (w_c_rd == RW'(r)) && (fw_wb || (fw_cnt != '0)))
                w_hazard = 1'b1;
        end
    end

    // Releases: wr_done clears, rd_done decrements once per port. Releasing a
    // non-busy register is ignored and flagged; a set racing a clear wins.
    always_comb begin
        logic          clr;
        logic [SW-1:0] dec;
        w_err_sb    = 1'b0;
        w_wbusy_nxt = '0;
        w_rcnt_nxt  = '0;
        for (int r = 0; r < N_REGS; r++) begin
            clr = 1'b0;
            dec = '0;
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (wr_done_valid_i[p] && (wr_done_reg_i[p*RW +: RW] == RW'(r))) clr = 1'b1;
            end
            for (int p = 0; p < READ_PORTS; p++) begin
                if (rd_done_valid_i[p] && (rd_done_reg_i[p*RW +: RW] == RW'(r)))
                    dec = dec + SW'(1);
            end
            if (clr && (!r_wbusy[r] || w_set[r])) w_err_sb = 1'b1;
            w_wbusy_nxt[r] = w_set[r] || (r_wbusy[r] && !clr);
            if (dec > SW'(r_rcnt[r])) begin
                w_err_sb = 1'b1;
                dec      = SW'(r_rcnt[r]);
            end
            w_rcnt_nxt[r] = RCNT_W'(SW'(r_rcnt[r]) + SW'(w_inc[r]) - dec);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_issue    <= 1'b0;
            r_fu       <= '0;
            r_rs       <= '0;
            r_rs_valid <= '0;
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
            r_id       <= '0;
            r_wbusy    <= '0;
            r_rcnt     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wbusy <= w_wbusy_nxt;
            r_rcnt  <= w_rcnt_nxt;
            if (w_err_sb || (w_accept && !w_fu_ok)) r_err <= 1'b1;
            if (w_accept) begin
                if (w_fu_ok) begin
                    r_state    <= S_HOLD;
                    r_issue    <= !w_hazard;
                    r_fu       <= instr_fu_i;
                    r_rs       <= instr_rs_i;
                    r_rs_valid <= instr_rs_valid_i;
                    r_rd       <= instr_rd_i;
                    r_rd_valid <= instr_rd_valid_i;
                    r_id       <= instr_id_i;
                end else begin
                    // Unknown unit: drop the instruction without issuing.
                    r_state <= S_IDLE;
                    r_issue <= 1'b0;
                end
            end else if (w_fire) begin
                r_state <= S_IDLE;
                r_issue <= 1'b0;
            end else if ((r_state == S_HOLD) && !r_issue) begin
                // Hazards only clear while holding, so once raised valid stays up.
                r_issue <= !w_hazard;
            end
        end
    end

    assign issue_valid_o    = w_issue_vec;
    assign issue_rs_o       = r_rs;
    assign issue_rs_valid_o = r_rs_valid;
    assign issue_rd_o       = r_rd;
    assign issue_rd_valid_o = r_rd_valid;
    assign issue_id_o       = r_id;
    assign wbusy_o          = r_wbusy;
    assign idle_o           = (r_state == S_IDLE) && (r_wbusy == '0) && (r_rcnt == '0);
    assign err_o            = r_err;

endmodule
